// File: rtl/adc_wfcap_pkg.sv
// Shared state encoding, packet tags and field widths for the adc_wfcap capture block.
package adc_wfcap_pkg;

  typedef enum logic [2:0] {IDLE, HDR, DATA, SUM, TRL} state_t;

  localparam logic [1:0] TAG_HDR  = 2'b10;
  localparam logic [1:0] TAG_TRL  = 2'b11;
  localparam int         TRTIME_W = 3;
  localparam int         TS_W     = 11;
  localparam int         COUNT_W  = 12;
  localparam int         SAMPLE_W = 12;
  localparam int         WORD_W   = 16;

  function automatic logic [WORD_W-1:0] hdr_word(input logic [TRTIME_W-1:0] trtime,
                                                 input logic [TS_W-1:0]     ts);
    return {TAG_HDR, trtime, ts};
  endfunction

  function automatic logic [WORD_W-1:0] trl_word(input logic               ovf,
                                                 input logic [COUNT_W-1:0] count);
    return {TAG_TRL, ovf, 1'b0, count};
  endfunction

endpackage

// File: rtl/adc_wfcap_ring.sv
// Sample ring: simple dual-port RAM, one write port and a registered read port (1-cycle latency).
module adc_wfcap_ring #(
  parameter int AW = 8,
  parameter int DW = 12
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // No reset on purpose so the array maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_wfcap.sv
// adc_wfcap: trigger-driven waveform capture for one ADC channel, framed onto a valid/ready stream.
// Define ADC_WFCAP_SUM_EN to insert a 16-bit sample-sum word between the data and the trailer.
module adc_wfcap
  import adc_wfcap_pkg::*;
#(
  parameter int AW  = 8,
  parameter int PRE = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [11:0]   DIN,
  input  logic          TRIG,
  input  logic [2:0]    TRTIME,
  input  logic          ENB,
  input  logic [7:0]    WINLEN,
  output logic [15:0]   DOUT,
  output logic          DVALID,
  input  logic          DREADY,
  output logic          DLAST,
  output logic          BUSY,
  output logic [7:0]    LOST
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW-1:0] PRE_A   = AW'(PRE);
  localparam logic [AW-1:0] OVR_LIM = AW'(DEPTH - 2);

  state_t                state;
  logic [AW-1:0]         waddr, raddr, backlog;
  logic [TS_W-1:0]       ts, ts_lat;
  logic [TRTIME_W-1:0]   trtime_lat;
  logic [7:0]            winlen_lat;
  logic [COUNT_W-1:0]    count;
  logic                  ovf, inflight, word_pushed;
  logic [SAMPLE_W-1:0]   ram_q;
  logic [WORD_W-1:0]     skid_data, push_word;
  logic                  skid_valid, skid_last;
  logic                  pop, accept, overrun, room, rd_en, push_en, push_last, data_done;
  logic [2:0]            load;
  state_t                after_data;
`ifdef ADC_WFCAP_SUM_EN
  logic [WORD_W-1:0]     sum;
`endif

  adc_wfcap_ring #(.AW(AW), .DW(SAMPLE_W)) u_ring (
    .CLK   (CLK),
    .we    (1'b1),
    .waddr (waddr),
    .wdata (DIN),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Credit check: words buffered plus a read in flight must leave a slot for one more push.
  assign pop       = DVALID & DREADY;
  assign accept    = TRIG & ENB & (state == IDLE);
  assign load      = {2'b0, DVALID} + {2'b0, skid_valid} + {2'b0, inflight} - {2'b0, pop};
  assign room      = (load <= 3'd1);
  assign backlog   = waddr - raddr;
  assign overrun   = (backlog >= OVR_LIM);
  assign data_done = (count == COUNT_W'(winlen_lat));
  assign rd_en     = (state == DATA) && !data_done && !overrun && (raddr != waddr) && room;
  assign BUSY      = (state != IDLE);
`ifdef ADC_WFCAP_SUM_EN
  assign after_data = SUM;
`else
  assign after_data = TRL;
`endif

  // Returning RAM data always wins; framing words go in only once all reads have drained.
  always_comb begin
    push_en   = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    if (inflight) begin
      push_en   = 1'b1;
      push_word = {4'b0000, ram_q};
    end else if (!word_pushed && room) begin
      case (state)
        HDR: begin
          push_en   = 1'b1;
          push_word = hdr_word(trtime_lat, ts_lat);
        end
`ifdef ADC_WFCAP_SUM_EN
        SUM: begin
          push_en   = 1'b1;
          push_word = sum;
        end
`endif
        TRL: begin
          push_en   = 1'b1;
          push_word = trl_word(ovf, count);
          push_last = 1'b1;
        end
        default: push_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      waddr       <= '0;
      raddr       <= '0;
      ts          <= '0;
      ts_lat      <= '0;
      trtime_lat  <= '0;
      winlen_lat  <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      inflight    <= 1'b0;
      word_pushed <= 1'b0;
      LOST        <= '0;
`ifdef ADC_WFCAP_SUM_EN
      sum         <= '0;
`endif
    end else begin
      waddr    <= waddr + 1'b1;
      ts       <= ts + 1'b1;
      inflight <= rd_en;
      if (rd_en) begin
        raddr <= raddr + 1'b1;
        if (count != '1) count <= count + 1'b1;
      end
`ifdef ADC_WFCAP_SUM_EN
      if (inflight) sum <= sum + WORD_W'(ram_q);
`endif
      if (TRIG && ENB && (state != IDLE) && (LOST != 8'hFF)) LOST <= LOST + 8'd1;
      if (push_en && !inflight) word_pushed <= 1'b1;

      case (state)
        IDLE: if (accept) begin
          raddr       <= waddr - PRE_A;
          trtime_lat  <= TRTIME;
          ts_lat      <= ts;
          winlen_lat  <= WINLEN;
          count       <= '0;
          ovf         <= 1'b0;
          word_pushed <= 1'b0;
`ifdef ADC_WFCAP_SUM_EN
          sum         <= '0;
`endif
          state       <= HDR;
        end
        // The buffer holds only the header here, so any pop is the header leaving.
        HDR: if (word_pushed && pop) begin
          word_pushed <= 1'b0;
          state       <= (winlen_lat == 8'd0) ? TRL : DATA;
        end
        DATA: if (data_done) begin
          state <= after_data;
        end else if (overrun) begin
          ovf   <= 1'b1;
          state <= after_data;
        end
`ifdef ADC_WFCAP_SUM_EN
        SUM: if (push_en && !inflight) begin
          word_pushed <= 1'b0;
          state       <= TRL;
        end
`endif
        TRL: if (word_pushed && pop && DLAST) begin
          word_pushed <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register plus one-entry skid; DOUT/DLAST only move when the head word is taken.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DOUT       <= '0;
      DVALID     <= 1'b0;
      DLAST      <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop || !DVALID) begin
      if (skid_valid) begin
        DOUT       <= skid_data;
        DLAST      <= skid_last;
        DVALID     <= 1'b1;
        skid_valid <= push_en;
        if (push_en) begin
          skid_data <= push_word;
          skid_last <= push_last;
        end
      end else begin
        DVALID <= push_en;
        if (push_en) begin
          DOUT  <= push_word;
          DLAST <= push_last;
        end
      end
    end else if (push_en) begin
      skid_valid <= 1'b1;
      skid_data  <= push_word;
      skid_last  <= push_last;
    end
  end

endmodule

// File: tb/tb_adc_wfcap.sv
// Directed self-checking bench for adc_wfcap; honours ADC_WFCAP_SUM_EN when it is defined.
`timescale 1ns/1ps
module tb_adc_wfcap;

  localparam int PRE = 32;
`ifdef ADC_WFCAP_SUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N, TRIG, ENB, DREADY;
  logic [11:0] DIN;
  logic [2:0]  TRTIME;
  logic [7:0]  WINLEN;
  logic [15:0] DOUT;
  logic        DVALID, DLAST, BUSY;
  logic [7:0]  LOST;

  adc_wfcap #(.AW(8), .PRE(PRE)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .DIN    (DIN),
    .TRIG   (TRIG),
    .TRTIME (TRTIME),
    .ENB    (ENB),
    .WINLEN (WINLEN),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .DREADY (DREADY),
    .DLAST  (DLAST),
    .BUSY   (BUSY),
    .LOST   (LOST)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference write pointer and timestamp; DIN is a ramp equal to the write address.
  logic [7:0]  mw;
  logic [10:0] mts;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mw  <= '0;
      mts <= '0;
    end else begin
      mw  <= mw + 8'd1;
      mts <= mts + 11'd1;
    end
  end
  assign DIN = {4'b0000, mw};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer monitor: captures {DLAST, DOUT} per handshake and checks stability during stalls.
  logic [16:0] rx[$];
  logic        stalled = 1'b0;
  logic [15:0] held;
  always @(negedge CLK) begin
    #2;
    if (RST_N) begin
      if (stalled) begin
        checkOutput("stall_valid", {31'b0, DVALID}, 32'd1);
        checkOutput("stall_hold", {16'b0, DOUT}, {16'b0, held});
      end
      if (DVALID && DREADY) rx.push_back({DLAST, DOUT});
      stalled = DVALID && !DREADY;
      held    = DOUT;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called at a negedge: pulses TRIG for one cycle and returns the expected start address and ts.
  task automatic applyStimulus(input logic [2:0] tr, input logic [7:0] wl,
                               output logic [7:0] start, output logic [10:0] tsv);
    TRIG   = 1'b1;
    TRTIME = tr;
    WINLEN = wl;
    start  = mw - 8'(PRE);
    tsv    = mts;
    @(negedge CLK);
    TRIG = 1'b0;
  endtask

  task automatic waitPacket(input int limit, input bit rnd);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < limit) begin
      @(negedge CLK);
      if (rnd) DREADY = 1'($urandom_range(0, 1));
      n++;
      done = (rx.size() > 0) && rx[rx.size()-1][16];
    end
    DREADY = 1'b1;
    checkOutput("pkt_done", {31'b0, done}, 32'd1);
  endtask

  task automatic checkPacket(input logic [2:0] tr, input logic [10:0] tsv, input logic [7:0] start,
                             input int wl, input bit ovf);
    int          n, ndata, expcnt;
    logic [15:0] sum;
    logic [7:0]  v;
    n   = rx.size();
    sum = '0;
    if (n < 2 + EXTRA) begin
      checkOutput("pkt_size", n, 2 + EXTRA);
      return;
    end
    ndata = n - 2 - EXTRA;
    checkOutput("header", {15'b0, rx[0]}, {15'b0, 1'b0, 2'b10, tr, tsv});
    if (ovf) checkOutput("ovf_short", {31'b0, ndata < wl}, 32'd1);
    else     checkOutput("pkt_len", n, wl + 2 + EXTRA);
    for (int i = 0; i < ndata; i++) begin
      v   = start + 8'(i);
      sum = sum + {8'b0, v};
      checkOutput($sformatf("data%0d", i), {15'b0, rx[1+i]}, {24'b0, v});
    end
`ifdef ADC_WFCAP_SUM_EN
    checkOutput("sum_word", {15'b0, rx[n-2]}, {16'b0, sum});
`endif
    expcnt = ovf ? ndata : wl;
    checkOutput("trailer", {15'b0, rx[n-1]}, {15'b0, 1'b1, 2'b11, ovf, 1'b0, 12'(expcnt)});
  endtask

  logic [7:0]  st;
  logic [10:0] tsv;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST_N = 1'b0; TRIG = 1'b0; ENB = 1'b1; TRTIME = '0; WINLEN = '0; DREADY = 1'b1;
    tick(3);
    checkOutput("rst_dvalid", {31'b0, DVALID}, 32'd0);
    checkOutput("rst_dout", {16'b0, DOUT}, 32'd0);
    checkOutput("rst_dlast", {31'b0, DLAST}, 32'd0);
    checkOutput("rst_busy", {31'b0, BUSY}, 32'd0);
    checkOutput("rst_lost", {24'b0, LOST}, 32'd0);
    RST_N = 1'b1;

    // Case 1: ramp, trigger at waddr 100 -> data 68..131.
    for (int i = 0; i < 300 && mw != 8'd100; i++) @(negedge CLK);
    applyStimulus(3'd3, 8'd64, st, tsv);
    checkOutput("start68", {24'b0, st}, 32'd68);
    checkOutput("busy_after_trig", {31'b0, BUSY}, 32'd1);
    waitPacket(400, 1'b0);
    checkPacket(3'd3, tsv, st, 64, 1'b0);
    checkOutput("lost0", {24'b0, LOST}, 32'd0);
    rx.delete();

    // Case 2: second trigger while busy is dropped; late WINLEN/TRTIME changes are ignored.
    applyStimulus(3'd5, 8'd64, st, tsv);
    tick(9);
    TRIG = 1'b1; TRTIME = 3'd7; WINLEN = 8'd10;
    @(negedge CLK);
    TRIG = 1'b0;
    waitPacket(400, 1'b0);
    tick(20);
    checkOutput("lost1", {24'b0, LOST}, 32'd1);
    checkOutput("one_pkt", rx.size(), 66 + EXTRA);
    checkPacket(3'd5, tsv, st, 64, 1'b0);
    rx.delete();

    DREADY = 1'b0;
    applyStimulus(3'd1, 8'd4, st, tsv);
    TRIG = 1'b1;
    tick(300);
    TRIG = 1'b0;
    checkOutput("lost_sat", {24'b0, LOST}, 32'd255);
    DREADY = 1'b1;
    waitPacket(400, 1'b0);
    rx.delete();

    // Case 3: consumer stalls after the header -> overrun.
    applyStimulus(3'd2, 8'd200, st, tsv);
    for (int i = 0; i < 20 && rx.size() == 0; i++) @(negedge CLK);
    DREADY = 1'b0;
    tick(300);
    DREADY = 1'b1;
    waitPacket(400, 1'b0);
    checkPacket(3'd2, tsv, st, 200, 1'b1);
    rx.delete();

    // Case 4: random backpressure, same packet shape as case 1.
    tick(5);
    applyStimulus(3'd3, 8'd64, st, tsv);
    waitPacket(2000, 1'b1);
    checkPacket(3'd3, tsv, st, 64, 1'b0);
    rx.delete();

    // Case 5a: WINLEN=0 -> header then trailer only.
    tick(5);
    applyStimulus(3'd0, 8'd0, st, tsv);
    waitPacket(100, 1'b0);
    checkOutput("w0_size", rx.size(), 2);
    if (rx.size() == 2) begin
      checkOutput("w0_header", {15'b0, rx[0]}, {15'b0, 1'b0, 2'b10, 3'd0, tsv});
      checkOutput("w0_trailer", {15'b0, rx[1]}, {15'b0, 17'h1C000});
    end
    rx.delete();

    // Case 5b: reset mid-DATA aborts, next trigger gives a clean packet.
    tick(5);
    applyStimulus(3'd4, 8'd64, st, tsv);
    tick(8);
    checkOutput("busy_mid", {31'b0, BUSY}, 32'd1);
    RST_N = 1'b0;
    #1;
    checkOutput("abort_dvalid", {31'b0, DVALID}, 32'd0);
    checkOutput("abort_busy", {31'b0, BUSY}, 32'd0);
    checkOutput("abort_dout", {16'b0, DOUT}, 32'd0);
    checkOutput("abort_lost", {24'b0, LOST}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    rx.delete();
    tick(5);
    applyStimulus(3'd6, 8'd64, st, tsv);
    waitPacket(400, 1'b0);
    checkPacket(3'd6, tsv, st, 64, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
